// File: rtl/qpsk_phase_sequencer.sv
// QPSK carrier phase sequencer: Gray-maps 2-bit symbols to 90-degree offsets and
// steps a 16-way phase mux select through CYCLES_PER_SYMBOL carrier periods per symbol.
module qpsk_phase_sequencer #(
    parameter int unsigned CYCLES_PER_SYMBOL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sample_tick,
    input  logic        sym_valid,
    input  logic [1:0]  sym_data,
    output logic        sym_ready,
    output logic [3:0]  select,
    output logic        out_valid,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] sym_count
);

    localparam int unsigned N  = 16 * CYCLES_PER_SYMBOL;
    localparam int unsigned SW = $clog2(N);

    typedef enum logic {StIdle, StRun} state_e;

    state_e         state_q, state_d;
    logic [3:0]     base_q, base_d;
    logic [SW-1:0]  s_q, s_d;
    logic [3:0]     select_q, select_d;
    logic           out_valid_q, out_valid_d;
    logic           underrun_q, underrun_d;
    logic [15:0]    sym_count_q, sym_count_d;

    logic           last;
    logic           xfer;
    logic [3:0]     new_base;

    always_comb begin
        new_base = 4'd0;
        unique case (sym_data)
            2'b00: new_base = 4'd0;
            2'b01: new_base = 4'd4;
            2'b11: new_base = 4'd8;
            2'b10: new_base = 4'd12;
            default: new_base = 4'd0;
        endcase
    end

    assign last      = (s_q == SW'(N - 1));
    assign sym_ready = rst_n & enable &
                       ((state_q == StIdle) | ((state_q == StRun) & sample_tick & last));
    assign xfer      = sym_valid & sym_ready;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        s_d         = s_q;
        select_d    = select_q;
        out_valid_d = out_valid_q;
        underrun_d  = 1'b0;
        sym_count_d = sym_count_q;

        unique case (state_q)
            StIdle: begin
                select_d    = 4'd0;
                out_valid_d = 1'b0;
                if (xfer) begin
                    state_d     = StRun;
                    base_d      = new_base;
                    s_d         = '0;
                    select_d    = new_base;
                    out_valid_d = 1'b1;
                    sym_count_d = sym_count_q + 16'd1;
                end
            end
            StRun: begin
                if (sample_tick) begin
                    if (!last) begin
                        s_d      = s_q + SW'(1);
                        // 4-bit add wraps the select 15 -> 0 inside each carrier period
                        select_d = base_q + s_q[3:0] + 4'd1;
                    end else if (xfer) begin
                        base_d      = new_base;
                        s_d         = '0;
                        select_d    = new_base;
                        out_valid_d = 1'b1;
                        sym_count_d = sym_count_q + 16'd1;
                    end else begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                        select_d    = 4'd0;
                        underrun_d  = enable;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_q      <= 4'd0;
            s_q         <= '0;
            select_q    <= 4'd0;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            sym_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            s_q         <= s_d;
            select_q    <= select_d;
            out_valid_q <= out_valid_d;
            underrun_q  <= underrun_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign select    = select_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == StRun);
    assign underrun  = underrun_q;
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_qpsk_phase_sequencer.sv
// Self-checking bench for qpsk_phase_sequencer: directed plan steps plus random traffic,
// checked against a symbol/sample-index reference model.
module tb_qpsk_phase_sequencer;

    localparam int unsigned CPS = 2;
    localparam int          N   = 16 * CPS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sample_tick;
    logic        sym_valid;
    logic [1:0]  sym_data;
    logic        sym_ready;
    logic [3:0]  select;
    logic        out_valid;
    logic        busy;
    logic        underrun;
    logic [15:0] sym_count;

    qpsk_phase_sequencer #(.CYCLES_PER_SYMBOL(CPS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sample_tick (sample_tick),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .sym_ready   (sym_ready),
        .select      (select),
        .out_valid   (out_valid),
        .busy        (busy),
        .underrun    (underrun),
        .sym_count   (sym_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: current symbol phase offset and sample index within the symbol
    bit m_run  = 0;
    int m_base = 0;
    int m_k    = 0;
    int m_cnt  = 0;
    bit m_und  = 0;
    int phase_of [4] = '{0, 4, 12, 8};

    int und_seen   = 0;
    int ready_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_base = 0; m_k = 0; m_cnt = 0; m_und = 0;
    endtask

    task automatic model_load(input logic [1:0] d);
        m_base = phase_of[d];
        m_k    = 0;
        m_run  = 1;
        m_cnt  = (m_cnt + 1) % 65536;
    endtask

    task automatic check_outputs();
        chk("select",    {28'd0, select},    m_run ? (m_base + m_k) % 16 : 0);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_run});
        chk("busy",      {31'd0, busy},      {31'd0, m_run});
        chk("underrun",  {31'd0, underrun},  {31'd0, m_und});
        chk("sym_count", {16'd0, sym_count}, m_cnt);
        if (underrun === 1'b1) und_seen++;
    endtask

    // One clock: check the combinational ready, clock the model alongside the DUT, check.
    task automatic step(output bit acc);
        bit rdy;
        #2;
        rdy = rst_n && enable && (!m_run || (sample_tick && m_k == N - 1));
        chk("sym_ready", {31'd0, sym_ready}, {31'd0, rdy});
        if (sym_ready === 1'b1) ready_seen++;
        @(posedge clk);
        acc   = 0;
        m_und = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_run) begin
            if (sym_valid && rdy) begin
                model_load(sym_data);
                acc = 1;
            end
        end else if (sample_tick) begin
            if (m_k < N - 1) begin
                m_k++;
            end else if (sym_valid && rdy) begin
                model_load(sym_data);
                acc = 1;
            end else begin
                m_run = 0;
                m_und = enable;
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        #300000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int idx;
        int gaps;
        int cnt0;
        logic [1:0] syms [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        int exp_first [4] = '{0, 4, 8, 12};

        // Reset held with a symbol offered
        rst_n = 1'b0; enable = 1'b1; sym_valid = 1'b1; sym_data = 2'b11; sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_select",    {28'd0, select},    0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_busy",      {31'd0, busy},      0);
        chk("rst_underrun",  {31'd0, underrun},  0);
        chk("rst_sym_count", {16'd0, sym_count}, 0);
        chk("rst_sym_ready", {31'd0, sym_ready}, 0);
        #2 rst_n = 1'b1;
        step(acc);
        chk("first_accept", {31'd0, acc}, 1);
        chk("first_select", {28'd0, select}, 8);
        chk("first_count",  {16'd0, sym_count}, 1);
        sym_valid = 1'b0; sample_tick = 1'b1; und_seen = 0;
        repeat (36) step(acc);
        chk("und_after_first", und_seen, 1);

        // Single symbol 01, tick every cycle
        sym_valid = 1'b1; sym_data = 2'b01;
        step(acc);
        chk("sym01_first_sel", {28'd0, select}, 4);
        sym_valid = 1'b0; und_seen = 0;
        repeat (34) step(acc);
        chk("sym01_underrun_once", und_seen, 1);
        chk("sym01_idle", {31'd0, out_valid}, 0);

        // Back-to-back symbols, tick every third cycle
        idx = 0; gaps = 0; cnt0 = m_cnt; und_seen = 0;
        sym_valid = 1'b1; sym_data = syms[0];
        for (int cyc = 0; cyc < 430; cyc++) begin
            sample_tick = (cyc % 3 == 2);
            step(acc);
            if (acc) begin
                chk("b2b_first_sel", {28'd0, select}, exp_first[idx]);
                idx++;
                if (idx == 4) sym_valid = 1'b0;
                else          sym_data  = syms[idx];
            end
            if (idx >= 1 && idx <= 3 && out_valid !== 1'b1) gaps++;
        end
        chk("b2b_symbols", idx, 4);
        chk("b2b_gaps", gaps, 0);
        chk("b2b_count_delta", (m_cnt - cnt0 + 65536) % 65536, 4);
        chk("b2b_underrun_once", und_seen, 1);

        // Enable dropped at sample 5 with the next symbol pending
        sample_tick = 1'b1; sym_valid = 1'b1; sym_data = 2'b10;
        step(acc);
        sym_data = 2'b00;
        for (int i = 0; i < 40 && m_k != 5; i++) step(acc);
        enable = 1'b0; und_seen = 0; ready_seen = 0;
        repeat (40) step(acc);
        chk("en_drop_ready", ready_seen, 0);
        chk("en_drop_underrun", und_seen, 0);
        chk("en_drop_idle", {31'd0, busy}, 0);
        sym_valid = 1'b0; enable = 1'b1;

        // Asynchronous reset at sample 17
        sym_valid = 1'b1; sym_data = 2'b00;
        step(acc);
        sym_valid = 1'b0;
        for (int i = 0; i < 40 && m_k != 17; i++) step(acc);
        #2 rst_n = 1'b0;
        #1;
        chk("async_select",    {28'd0, select},    0);
        chk("async_out_valid", {31'd0, out_valid}, 0);
        chk("async_busy",      {31'd0, busy},      0);
        chk("async_count",     {16'd0, sym_count}, 0);
        model_reset();
        #3 rst_n = 1'b1;
        step(acc);
        chk("post_rst_busy",  {31'd0, busy},      0);
        chk("post_rst_count", {16'd0, sym_count}, 0);

        // sym_count wrap
        force dut.sym_count_q = 16'hffff;
        @(posedge clk);
        #1;
        release dut.sym_count_q;
        m_cnt = 65535;
        chk("preload_count", {16'd0, sym_count}, 65535);
        sym_valid = 1'b1; sym_data = 2'b01;
        step(acc);
        chk("wrap_count", {16'd0, sym_count}, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            enable      = ($urandom_range(0, 9) != 0);
            sample_tick = ($urandom_range(0, 2) == 0);
            sym_valid   = ($urandom_range(0, 3) != 0);
            sym_data    = 2'($urandom_range(0, 3));
            step(acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qpsk_phase_sequencer.md
# qpsk_phase_sequencer

Drives the 4-bit select of the 16-way carrier phase multiplexer in the QPSK modulator. It accepts 2-bit symbols over a valid/ready handshake and Gray-maps each one to a 90° phase offset. For each symbol it steps the mux select through a whole number of carrier periods, starting at that offset, and advances one sample per `sample_tick`. Back-to-back symbols are spliced with no gap sample. Gaps in symbol supply are flagged as underruns.

## Interface
- `CYCLES_PER_SYMBOL`, default 2: carrier periods per symbol, legal range 1..16. Samples per symbol: `N = 16*CYCLES_PER_SYMBOL`.
- `clk`, in, 1: the only clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `enable`, in, 1: allows new symbols to be accepted.
- `sample_tick`, in, 1: single-cycle strobe. Advances the output sample.
- `sym_valid`, in, 1: symbol offered.
- `sym_data`, in, 2: symbol dibit.
- `sym_ready`, out, 1: symbol accepted this cycle if `sym_valid` is also high.
- `select`, out, 4: phase select to the mux.
- `out_valid`, out, 1: `select` carries a live symbol sample.
- `busy`, out, 1: high in the RUN state.
- `underrun`, out, 1: one-cycle pulse when a symbol ends with no successor while `enable` is high.
- `sym_count`, out, 16: count of accepted symbols. Wraps modulo 2^16.

## Operation
- States: IDLE and RUN. Registers: `state`, `base[3:0]`, sample counter `s` (width `clog2(N)`), `select`, `out_valid`, `underrun`, `sym_count`.
- Gray phase map, from `sym_data` to base:
  - 00 → 0 (0°)
  - 01 → 4 (90°)
  - 11 → 8 (180°)
  - 10 → 12 (270°)
- `last = (s == N-1)`.
- `sym_ready` is combinational: `rst_n & enable & (IDLE | (RUN & sample_tick & last))`.
- Transfer: `sym_valid & sym_ready`.
- IDLE:
  - `select` = 0, `out_valid` = 0.
  - On transfer: `base` ← map(`sym_data`), `s` ← 0, `select` ← map(`sym_data`), `out_valid` ← 1, go to RUN, `sym_count` += 1.
  - `sample_tick` in IDLE has no effect.
- RUN, on `sample_tick` with `!last`: `s` += 1, `select` ← `base + s + 1`. The add is 4-bit and wraps mod 16, so select goes 15 → 0 within a period.
- RUN, on `sample_tick` with `last`:
  - If transfer: load the new symbol exactly as from IDLE and stay in RUN. The next `select` is the new base, so there is no bubble.
  - Else if `enable`: go to IDLE, `out_valid` ← 0, `select` ← 0, `underrun` pulses 1 for one cycle.
  - Else (`enable` low): go to IDLE with no underrun.
- RUN without `sample_tick`: all registers hold.
- Deasserting `enable` mid-symbol: the current symbol completes all N samples, then the block goes to IDLE. No new symbol is accepted.
- Changes to `sym_data` while `sym_valid` is high but not accepted are ignored.
- `busy` = (state == RUN).

## Timing
- Reset (asynchronous, while `rst_n` = 0) takes effect immediately:
  - state = IDLE, `s` = 0, `base` = 0
  - `select` = 0, `out_valid` = 0, `busy` = 0, `underrun` = 0
  - `sym_count` = 0, `sym_ready` = 0
- Reset mid-symbol aborts the symbol immediately. No underrun is flagged.
- Accept-to-output latency: 1 clock. A transfer at edge T gives `select` = base and `out_valid` = 1 after T.
- Each symbol presents exactly N samples. Sample k (k = 0..N-1) is live from the tick that produces it until the next tick.
- Symbol boundary: the last sample is replaced by the new symbol's sample 0 on the same tick edge.
- `underrun` asserts the cycle after the final tick and clears one cycle later.
- `sample_tick` and transfer coincide only at `last`. In IDLE, a transfer loads the symbol regardless of `sample_tick`.

## Test plan
- Reset with `sym_valid` = 1, `sym_data` = 11 → while reset is held, all outputs are 0 and `sym_ready` = 0. Release with `enable` = 1 → `sym_ready` = 1, the transfer occurs, and the next cycle shows `select` = 8, `out_valid` = 1, `sym_count` = 1.
- `CYCLES_PER_SYMBOL` = 2, one symbol 01, `sample_tick` every cycle, `sym_valid` then low → `select` runs 4..15, 0..15, 0..3 (32 samples). Then `out_valid` = 0 and `underrun` is high for exactly one cycle.
- Back-to-back symbols 00, 01, 11, 10 with `sym_valid` held high and `sample_tick` every 3rd cycle → no `out_valid` gap. The first samples of the successive symbols are 0, 4, 8, 12. `sym_count` = 4. One underrun, after the last symbol.
- `enable` dropped at sample 5 of a symbol with the next symbol pending → the symbol completes all 32 samples, `sym_ready` stays 0, the block goes to IDLE, and there is no underrun.
- `rst_n` pulsed low at sample 17 → `select` and `out_valid` go to 0 asynchronously. After release the block is in IDLE with `sym_count` = 0.
- `sym_count` preloaded to 65535 by forcing it, then one transfer → `sym_count` wraps to 0.
